// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 16-bit RISC datapath: FETCH/DECODE/EXEC/MEM/WB
// with a memory handshake timeout, run/idle gating, illegal-opcode halt and a retired-instruction count.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             ir_write,
  output logic             jump,
  output logic             beq,
  output logic             bne,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             mem_req,
  output logic [2:0]       state,
  output logic             busy,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [3:0]    op_q;
  logic [TW-1:0] tcnt_q;

  logic is_lw, is_sw, is_r, is_beq, is_bne, is_jmp, is_illegal;
  logic decode_active, tmo_hit;
  state_t commit_next;

  assign is_lw      = (op_q == 4'd0);
  assign is_sw      = (op_q == 4'd1);
  assign is_r       = (op_q >= 4'd2) && (op_q <= 4'd9);
  assign is_beq     = (op_q == 4'd11);
  assign is_bne     = (op_q == 4'd12);
  assign is_jmp     = (op_q == 4'd13);
  assign is_illegal = !(is_lw || is_sw || is_r || is_beq || is_bne || is_jmp);

  assign decode_active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                         (state_q == S_MEM)    || (state_q == S_WB);
  // An ack in the final allowed wait cycle takes priority over the timeout.
  assign tmo_hit     = (state_q == S_MEM) && !mem_ack && (tcnt_q == TW'(MEM_TIMEOUT - 1));
  assign commit_next = run ? S_FETCH : S_IDLE;

  assign state = state_q;
  assign busy  = (state_q == S_FETCH) || decode_active;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    jump       = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: state_d = is_illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_beq || is_bne || is_jmp) begin
          pc_write = 1'b1;
          state_d  = commit_next;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if (is_sw) begin
            pc_write = 1'b1;
            state_d  = commit_next;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = commit_next;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    if (decode_active) begin
      alu_src    = is_lw || is_sw;
      reg_dst    = is_r;
      mem_to_reg = is_lw;
      beq        = is_beq;
      bne        = is_bne;
      jump       = is_jmp;
      if (is_lw || is_sw)        alu_op = 2'b10;
      else if (is_beq || is_bne) alu_op = 2'b01;
      else                       alu_op = 2'b00;
    end
    mem_read  = mem_req && is_lw;
    mem_write = mem_req && is_sw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      tcnt_q      <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
      retired     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) op_q <= opcode;
      if (state_q != S_MEM)   tcnt_q <= '0;
      else if (!mem_ack)      tcnt_q <= tcnt_q + 1'b1;
      if (state_q == S_DECODE && is_illegal) illegal_op <= 1'b1;
      if (tmo_hit)  mem_timeout <= 1'b1;
      if (pc_write) retired <= retired + 1'b1;
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the 16-bit RISC datapath.
- Latches the 4-bit opcode from the datapath and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives all datapath control strobes, plus PC and instruction-register enables.
- Handles a variable-latency data-memory req/ack handshake with timeout, run/idle gating, illegal-opcode halt and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM waiting for mem_ack before timeout halt (>=1).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- run  in  1  level; 1 = execute instructions, 0 = park in IDLE at the next instruction boundary.
- opcode  in  4  instr[15:12] from the datapath; sampled at the end of FETCH.
- mem_ack  in  1  data memory completion; sampled only in MEM.
- pc_write  out  1  single-cycle commit pulse; PC loads pc_next.
- ir_write  out  1  instruction register load enable.
- jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write  out  1 each  datapath controls.
- alu_op  out  2  00 R-type, 01 branch compare (SUB), 10 address add.
- mem_req  out  1  data memory request.
- state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6.
- busy  out  1  high in states 1..5.
- illegal_op  out  1  sticky; set on undefined opcode.
- mem_timeout  out  1  sticky; set on MEM timeout.
- retired  out  CNT_W  count of pc_write pulses; wraps to 0.

Behaviour:
- Reset (asynchronous): state=IDLE, op_q=0, timeout counter=0, retired=0. All outputs 0, including both sticky flags.
- Opcode map:
  - 0000 LW, 0001 SW.
  - 0010-1001 R-type: ADD SUB INV LSL LSR AND OR SLT.
  - 1011 BEQ, 1100 BNE, 1101 JMP.
  - 1010, 1110, 1111 illegal.
- op_q is loaded from opcode on the FETCH->DECODE edge. All decode from DECODE onward uses op_q, never the live opcode.
- Static decode from op_q, held valid in DECODE/EXEC/MEM/WB; 0 in IDLE/FETCH/HALT:
  - alu_src = LW|SW.
  - reg_dst = R-type.
  - mem_to_reg = LW.
  - beq/bne/jump = matching opcode.
  - alu_op per the table above.
- Transitions:
  - IDLE -> FETCH when run=1.
  - FETCH (ir_write=1, exactly 1 cycle) -> DECODE.
  - DECODE: illegal -> HALT and set illegal_op; else -> EXEC.
  - EXEC, BEQ/BNE/JMP: pc_write=1; datapath selects branch/jump target from zero flag. Next state = FETCH if run=1, else IDLE.
  - EXEC, LW/SW -> MEM. R-type -> WB.
  - MEM: mem_req=1, mem_read=LW, mem_write=SW, all held until the ack cycle inclusive. On mem_ack=1: SW asserts pc_write that cycle and goes to FETCH/IDLE (per run); LW goes to WB.
  - WB: reg_write=1 and pc_write=1 for exactly 1 cycle -> FETCH/IDLE per run.
  - HALT: all strobes 0, stays until reset.
- Cycle counts with immediate ack: branch/jump 3, R-type 4, SW 4, LW 5. Each ack wait state adds 1.
- Timeout counter: cleared on MEM entry, increments each MEM cycle with mem_ack=0. Reaching MEM_TIMEOUT -> HALT, mem_timeout=1, no pc_write. mem_ack in the same cycle the count reaches the limit wins (normal completion).
- pc_write and reg_write: never asserted outside the cases above; at most one pc_write per instruction.
- run=0 mid-instruction: the current instruction completes; the run check is made only at commit.
- retired increments on each pc_write; all-ones wraps to 0.
- mem_ack outside MEM is ignored.
- Reset asserted in any state, including MEM with mem_req high: immediate return to reset values; no pending write completes.

Test Plan:
- Reset, run=1, opcode=0010 (ADD), mem_ack=0: states 1,2,3,5,1. ir_write in cycle 1. reg_write=pc_write=1 only in WB with reg_dst=1, alu_op=00. retired=1 after 4 cycles.
- LW with mem_ack delayed 3 cycles: mem_req/mem_read high 4 cycles in MEM, then WB with mem_to_reg=1, reg_write=1. Total 8 cycles, one pc_write.
- SW, MEM_TIMEOUT=4, mem_ack never: 4 MEM cycles, then state=6, mem_timeout=1, pc_write never pulses, retired unchanged. Repeat with ack on the 4th MEM cycle: completes normally.
- BEQ then JMP, run dropped during JMP EXEC: BEQ commits in EXEC with beq=1, alu_op=01, alu_src=0. JMP commits with jump=1, then state=0, busy=0. Raising run resumes at FETCH.
- opcode=1110: DECODE -> HALT, illegal_op=1, no reg_write/pc_write. Further run/mem_ack toggles have no effect until reset.
- Reset pulse mid-MEM with mem_write=1: all outputs 0 asynchronously (before the next clk edge), state=0, retired=0, sticky flags cleared.
- Preload-free wrap check (CNT_W=4): 16 JMPs -> retired returns to 0.
